// File: rtl/thread_pkg.sv
// Shared definitions for the execution thread: FSM states, instruction
// layout, opcode constants, lock cause codes and the decode checker.
package thread_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_WAIT_I   = 4'd2,
        ST_DECODE   = 4'd3,
        ST_READ     = 4'd4,
        ST_EXEC     = 4'd5,
        ST_ALU_WAIT = 4'd6,
        ST_RETIRE   = 4'd7,
        ST_LOCKED   = 4'd8
    } state_t;

    // Field bit positions within the low 32 bits of the fetched word
    localparam int OPC_LO   = 20;
    localparam int MODE_LO  = 16;
    localparam int RSRC_LO  = 10;
    localparam int RDEST_LO = 4;
    localparam int FLAGS_LO = 0;

    localparam int REG_IDX_W = 6;

    // Packed view of the instruction; member order matches the bit positions above
    typedef struct packed {
        logic [11:0]          opcode;
        logic [3:0]           mode;
        logic [REG_IDX_W-1:0] rsrc;
        logic [REG_IDX_W-1:0] rdest;
        logic [3:0]           flags;
    } inst_t;

    localparam logic [11:0] OP_MOV       = 12'h115;
    localparam logic [11:0] OP_BZ        = 12'h120;
    localparam logic [11:0] OP_ALU_LIMIT = 12'h100;

    localparam logic [3:0] MODE_REG = 4'd1;
    localparam logic [3:0] MODE_IMM = 4'd2;

    localparam logic [2:0] CAUSE_NONE    = 3'd0;
    localparam logic [2:0] CAUSE_FLAG    = 3'd1;
    localparam logic [2:0] CAUSE_REG     = 3'd2;
    localparam logic [2:0] CAUSE_OP      = 3'd3;
    localparam logic [2:0] CAUSE_TIMEOUT = 3'd4;

    // Ordered decode checks; the first failing check determines the cause
    function automatic logic [2:0] decode_cause(input inst_t inst, input int num_regs);
        logic [2:0] cause;
        logic       op_ok;
        logic       mode_ok;
        op_ok   = (inst.opcode < OP_ALU_LIMIT) || (inst.opcode == OP_MOV) || (inst.opcode == OP_BZ);
        mode_ok = (inst.mode == MODE_REG) || (inst.mode == MODE_IMM);
        if (inst.flags[0] == 1'b0) begin
            cause = CAUSE_FLAG;
        end else if ((int'(inst.rdest) >= num_regs) ||
                     ((inst.mode == MODE_REG) && (int'(inst.rsrc) >= num_regs))) begin
            cause = CAUSE_REG;
        end else if (!op_ok || !mode_ok) begin
            cause = CAUSE_OP;
        end else begin
            cause = CAUSE_NONE;
        end
        return cause;
    endfunction

endpackage

// File: rtl/thread_regfile.sv
// Architectural register file: two registered read ports, one write port.
// Contents survive a thread soft reset; only the full reset clears them.
module thread_regfile
    import thread_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int NUM_REGS = 40
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] rd1_addr,
    input  logic [REG_IDX_W-1:0] rd2_addr,
    output logic [DATA_W-1:0]    rd1_data,
    output logic [DATA_W-1:0]    rd2_data,
    input  logic                 wr_en,
    input  logic [REG_IDX_W-1:0] wr_addr,
    input  logic [DATA_W-1:0]    wr_data
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    // Storage update and registered reads; out-of-range reads return zero
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            rd1_data <= '0;
            rd2_data <= '0;
        end else begin
            if (wr_en && (int'(wr_addr) < NUM_REGS)) begin
                regs[wr_addr] <= wr_data;
            end
            rd1_data <= (int'(rd1_addr) < NUM_REGS) ? regs[rd1_addr] : '0;
            rd2_data <= (int'(rd2_addr) < NUM_REGS) ? regs[rd2_addr] : '0;
        end
    end

endmodule

// File: rtl/thread_exec_unit.sv
// Single-context execution thread: fetch over L1-I, decode/verify, execute
// MOV / ALU / branch-if-zero, with an ALU req/done handshake and timeout lock.
module thread_exec_unit
    import thread_pkg::*;
#(
    parameter int DATA_W      = 64,
    parameter int INST_W      = 32,
    parameter int NUM_REGS    = 40,
    parameter int PC_STEP     = 4,
    parameter int RESET_PC    = 0,
    parameter int ALU_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              thread_reset,
    input  logic              enable,
    input  logic              halt_req,
    output logic              in_use,
    output logic              locked,
    output logic [2:0]        lock_cause,
    output logic              retired,
    output logic [DATA_W-1:0] pc_out,
    output logic              read_l1i,
    output logic [DATA_W-1:0] l1i_addr,
    input  logic [DATA_W-1:0] l1i_data,
    input  logic              l1i_ready,
    output logic              alu_req,
    output logic [7:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_res,
    input  logic              alu_done
);

    localparam int CNT_W = $clog2(ALU_TIMEOUT + 1);

    state_t               state;
    inst_t                inst;
    logic [CNT_W-1:0]     alu_cnt;
    logic [REG_IDX_W-1:0] rd1_addr;
    logic [REG_IDX_W-1:0] rd2_addr;
    logic [DATA_W-1:0]    rd1_data;
    logic [DATA_W-1:0]    rd2_data;
    logic                 wr_en;
    logic [DATA_W-1:0]    wr_data;
    logic                 is_mov;
    logic                 is_bz;
    logic [DATA_W-1:0]    rsrc_zext;
    logic [DATA_W-1:0]    rsrc_off;
    logic [DATA_W-1:0]    pc_seq;
    logic [DATA_W-1:0]    pc_branch;
    logic [2:0]           dec_cause;
    logic [INST_W-1:0]    inst_word;
    logic                 unused_bits;

    assign inst_word   = l1i_data[INST_W-1:0];
    assign unused_bits = ^{l1i_data[DATA_W-1:INST_W], inst.flags[3:1]};

    thread_regfile #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .rd1_addr (rd1_addr),
        .rd2_addr (rd2_addr),
        .rd1_data (rd1_data),
        .rd2_data (rd2_data),
        .wr_en    (wr_en),
        .wr_addr  (inst.rdest),
        .wr_data  (wr_data)
    );

    // Decode helpers, next-PC arithmetic (modulo 2^DATA_W) and register write port
    always_comb begin
        is_mov    = (inst.opcode == OP_MOV);
        is_bz     = (inst.opcode == OP_BZ);
        rsrc_zext = DATA_W'(inst.rsrc);
        rsrc_off  = {{(DATA_W-REG_IDX_W){inst.rsrc[REG_IDX_W-1]}}, inst.rsrc} * DATA_W'(PC_STEP);
        pc_seq    = pc_out + DATA_W'(PC_STEP);
        pc_branch = (rd1_data == '0) ? (pc_out + rsrc_off) : pc_seq;
        rd1_addr  = (is_mov && (inst.mode == MODE_REG)) ? inst.rsrc : inst.rdest;
        rd2_addr  = inst.rsrc;
        dec_cause = decode_cause(inst, NUM_REGS);
        if ((state == ST_EXEC) && is_mov) begin
            wr_en   = 1'b1;
            wr_data = (inst.mode == MODE_REG) ? rd1_data : rsrc_zext;
        end else if ((state == ST_ALU_WAIT) && alu_done) begin
            wr_en   = 1'b1;
            wr_data = alu_res;
        end else begin
            wr_en   = 1'b0;
            wr_data = '0;
        end
    end

    // Thread FSM with registered outputs; pulses default low every cycle
    always_ff @(posedge clk) begin
        if (rst || thread_reset) begin
            state      <= ST_IDLE;
            inst       <= '0;
            alu_cnt    <= '0;
            in_use     <= 1'b0;
            locked     <= 1'b0;
            lock_cause <= CAUSE_NONE;
            retired    <= 1'b0;
            pc_out     <= DATA_W'(RESET_PC);
            l1i_addr   <= DATA_W'(RESET_PC);
            read_l1i   <= 1'b0;
            alu_req    <= 1'b0;
            alu_op     <= 8'h00;
            alu_a      <= '0;
            alu_b      <= '0;
        end else begin
            read_l1i <= 1'b0;
            alu_req  <= 1'b0;
            retired  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (enable && !halt_req) begin
                        state    <= ST_FETCH;
                        in_use   <= 1'b1;
                        read_l1i <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    state <= ST_WAIT_I;
                end
                ST_WAIT_I: begin
                    if (l1i_ready) begin
                        inst  <= inst_t'(inst_word[31:0]);
                        state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (dec_cause != CAUSE_NONE) begin
                        state      <= ST_LOCKED;
                        locked     <= 1'b1;
                        lock_cause <= dec_cause;
                    end else begin
                        state <= ST_READ;
                    end
                end
                ST_READ: begin
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (is_mov) begin
                        pc_out   <= pc_seq;
                        l1i_addr <= pc_seq;
                        retired  <= 1'b1;
                        state    <= ST_RETIRE;
                    end else if (is_bz) begin
                        pc_out   <= pc_branch;
                        l1i_addr <= pc_branch;
                        retired  <= 1'b1;
                        state    <= ST_RETIRE;
                    end else begin
                        alu_op  <= inst.opcode[7:0];
                        alu_a   <= rd1_data;
                        alu_b   <= (inst.mode == MODE_REG) ? rd2_data : rsrc_zext;
                        alu_req <= 1'b1;
                        alu_cnt <= '0;
                        state   <= ST_ALU_WAIT;
                    end
                end
                ST_ALU_WAIT: begin
                    alu_cnt <= alu_cnt + 1'b1;
                    if (alu_done) begin
                        pc_out   <= pc_seq;
                        l1i_addr <= pc_seq;
                        retired  <= 1'b1;
                        state    <= ST_RETIRE;
                    end else if (alu_cnt == CNT_W'(ALU_TIMEOUT - 1)) begin
                        state      <= ST_LOCKED;
                        locked     <= 1'b1;
                        lock_cause <= CAUSE_TIMEOUT;
                    end
                end
                ST_RETIRE: begin
                    if (halt_req || !enable) begin
                        state <= ST_IDLE;
                    end else begin
                        state    <= ST_FETCH;
                        read_l1i <= 1'b1;
                    end
                end
                ST_LOCKED: begin
                    state <= ST_LOCKED;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_thread_exec_unit.sv
// Directed self-checking bench for thread_exec_unit with hand-computed expectations.
module tb_thread_exec_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        thread_reset = 1'b0;
    logic        enable = 1'b0;
    logic        halt_req = 1'b0;
    logic        in_use;
    logic        locked;
    logic [2:0]  lock_cause;
    logic        retired;
    logic [63:0] pc_out;
    logic        read_l1i;
    logic [63:0] l1i_addr;
    logic [63:0] l1i_data = 64'h0;
    logic        l1i_ready = 1'b0;
    logic        alu_req;
    logic [7:0]  alu_op;
    logic [63:0] alu_a;
    logic [63:0] alu_b;
    logic [63:0] alu_res = 64'h0;
    logic        alu_done = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    thread_exec_unit dut (
        .clk(clk), .rst(rst), .thread_reset(thread_reset), .enable(enable),
        .halt_req(halt_req), .in_use(in_use), .locked(locked), .lock_cause(lock_cause),
        .retired(retired), .pc_out(pc_out), .read_l1i(read_l1i), .l1i_addr(l1i_addr),
        .l1i_data(l1i_data), .l1i_ready(l1i_ready), .alu_req(alu_req), .alu_op(alu_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_res(alu_res), .alu_done(alu_done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] enc(input logic [11:0] op, input logic [3:0] mode,
                                        input logic [5:0] rs, input logic [5:0] rd,
                                        input logic [3:0] fl);
        return {op, mode, rs, rd, fl};
    endfunction

    // Wait for the fetch request, then return the instruction lat cycles later
    task automatic fetch(input logic [31:0] inst, input int lat, input logic [63:0] exp_pc);
        int n = 0;
        while (!read_l1i && n < 40) begin
            tick();
            n++;
        end
        check("fetch_req", read_l1i, 1'b1);
        check("fetch_addr", l1i_addr, exp_pc);
        tick();
        check("fetch_pulse", read_l1i, 1'b0);
        repeat (lat) tick();
        l1i_data  = {32'h0, inst};
        l1i_ready = 1'b1;
        tick();
        l1i_ready = 1'b0;
        l1i_data  = 64'h0;
    endtask

    // Service one ALU request; done is sampled dly+1 edges after req is seen
    task automatic do_alu(input logic [7:0] op, input logic [63:0] a, input logic [63:0] b,
                          input int dly, input logic [63:0] res, input logic halt);
        int n = 0;
        while (!alu_req && n < 40) begin
            tick();
            n++;
        end
        check("alu_req", alu_req, 1'b1);
        check("alu_op", alu_op, op);
        check("alu_a", alu_a, a);
        check("alu_b", alu_b, b);
        if (halt) halt_req = 1'b1;
        tick();
        check("alu_req_pulse", alu_req, 1'b0);
        repeat (dly - 1) tick();
        alu_done = 1'b1;
        alu_res  = res;
        tick();
        alu_done = 1'b0;
        alu_res  = 64'h0;
    endtask

    task automatic wait_retire(input logic [63:0] exp_pc);
        int n = 0;
        while (!retired && n < 40) begin
            tick();
            n++;
        end
        check("retired", retired, 1'b1);
        check("retire_pc", pc_out, exp_pc);
        tick();
        check("retired_pulse", retired, 1'b0);
    endtask

    task automatic wait_lock(input logic [2:0] cause, input logic [63:0] exp_pc);
        int n = 0;
        while (!locked && n < 40) begin
            tick();
            n++;
        end
        check("locked", locked, 1'b1);
        check("lock_cause", lock_cause, cause);
        check("lock_pc", pc_out, exp_pc);
    endtask

    task automatic soft_reset();
        thread_reset = 1'b1;
        tick();
        thread_reset = 1'b0;
        check("trst_locked", locked, 1'b0);
        check("trst_cause", lock_cause, 3'd0);
        check("trst_pc", pc_out, 64'h0);
        check("trst_in_use", in_use, 1'b0);
    endtask

    logic [31:0] lk_inst  [6];
    logic [2:0]  lk_cause [6];

    initial begin
        int n;
        int reads;
        lk_inst[0] = enc(12'h115, 4'd2, 6'd1,  6'd45, 4'd1); lk_cause[0] = 3'd2;
        lk_inst[1] = enc(12'h001, 4'd1, 6'd40, 6'd1,  4'd1); lk_cause[1] = 3'd2;
        lk_inst[2] = enc(12'h100, 4'd2, 6'd0,  6'd1,  4'd1); lk_cause[2] = 3'd3;
        lk_inst[3] = enc(12'h116, 4'd2, 6'd0,  6'd1,  4'd1); lk_cause[3] = 3'd3;
        lk_inst[4] = enc(12'h115, 4'd3, 6'd0,  6'd1,  4'd1); lk_cause[4] = 3'd3;
        lk_inst[5] = enc(12'h115, 4'd2, 6'd0,  6'd45, 4'd0); lk_cause[5] = 3'd1;

        repeat (3) tick();
        check("rst_in_use", in_use, 1'b0);
        check("rst_locked", locked, 1'b0);
        check("rst_pc", pc_out, 64'h0);
        check("rst_read", read_l1i, 1'b0);
        check("rst_alu_req", alu_req, 1'b0);
        rst    = 1'b0;
        enable = 1'b1;
        tick();
        check("in_use_set", in_use, 1'b1);

        // MOV r3,#0x2A with late L1-I, then r1=5, r2=7
        fetch(enc(12'h115, 4'd2, 6'h2A, 6'd3, 4'd1), 3, 64'h0);
        wait_retire(64'h4);
        fetch(enc(12'h115, 4'd2, 6'd5, 6'd1, 4'd1), 0, 64'h4);
        wait_retire(64'h8);
        fetch(enc(12'h115, 4'd2, 6'd7, 6'd2, 4'd1), 1, 64'h8);
        wait_retire(64'hC);

        // ADD r1,r2 register mode: 5 + 7 = 12
        fetch(enc(12'h001, 4'd1, 6'd2, 6'd1, 4'd1), 0, 64'hC);
        do_alu(8'h01, 64'd5, 64'd7, 2, 64'd12, 1'b0);
        wait_retire(64'h10);

        // BZ r4,-2 at 0x10 with r4=0 -> 0x08
        fetch(enc(12'h120, 4'd2, 6'h3E, 6'd4, 4'd1), 0, 64'h10);
        wait_retire(64'h8);
        // read back r1 through the ALU operand path
        fetch(enc(12'h002, 4'd2, 6'd0, 6'd1, 4'd1), 0, 64'h8);
        do_alu(8'h02, 64'd12, 64'd0, 1, 64'd12, 1'b0);
        wait_retire(64'hC);
        fetch(enc(12'h115, 4'd2, 6'd1, 6'd4, 4'd1), 0, 64'hC);
        wait_retire(64'h10);
        // BZ r4,-2 with r4=1 -> fall through to 0x14
        fetch(enc(12'h120, 4'd2, 6'h3E, 6'd4, 4'd1), 0, 64'h10);
        wait_retire(64'h14);
        fetch(enc(12'h003, 4'd2, 6'd9, 6'd3, 4'd1), 0, 64'h14);
        do_alu(8'h03, 64'h2A, 64'd9, 1, 64'h2A, 1'b0);
        wait_retire(64'h18);

        // ALU timeout: lock exactly 16 cycles after entering ALU_WAIT
        fetch(enc(12'h004, 4'd2, 6'd0, 6'd5, 4'd1), 0, 64'h18);
        n = 0;
        while (!alu_req && n < 40) begin
            tick();
            n++;
        end
        check("to_alu_req", alu_req, 1'b1);
        n = 0;
        while (!locked && n < 40) begin
            tick();
            n++;
        end
        check("to_cycles", 64'(n), 64'd16);
        check("to_cause", lock_cause, 3'd4);
        check("to_pc", pc_out, 64'h18);

        soft_reset();
        fetch(enc(12'h003, 4'd2, 6'd0, 6'd3, 4'd1), 0, 64'h0);
        do_alu(8'h03, 64'h2A, 64'd0, 1, 64'h2A, 1'b0);
        wait_retire(64'h4);

        // done on the timeout cycle wins
        fetch(enc(12'h005, 4'd2, 6'd0, 6'd6, 4'd1), 0, 64'h4);
        do_alu(8'h05, 64'd0, 64'd0, 15, 64'h77, 1'b0);
        check("late_done_retired", retired, 1'b1);
        check("late_done_unlocked", locked, 1'b0);
        wait_retire(64'h8);

        // flags=0 locks with PC frozen at the faulting instruction
        fetch(enc(12'h115, 4'd2, 6'd1, 6'd7, 4'd0), 0, 64'h8);
        wait_lock(3'd1, 64'h8);

        for (int i = 0; i < 6; i++) begin
            soft_reset();
            fetch(lk_inst[i], 0, 64'h0);
            wait_lock(lk_cause[i], 64'h0);
        end

        // halt mid-ALU on opcode 0xFF (upper ALU boundary); r6 survived soft resets
        soft_reset();
        fetch(enc(12'h0FF, 4'd2, 6'd0, 6'd6, 4'd1), 0, 64'h0);
        do_alu(8'hFF, 64'h77, 64'd0, 2, 64'h77, 1'b1);
        wait_retire(64'h4);
        reads = 0;
        for (int i = 0; i < 6; i++) begin
            if (read_l1i) reads++;
            tick();
        end
        check("halt_no_fetch", 64'(reads), 64'd0);
        check("halt_in_use", in_use, 1'b1);
        halt_req = 1'b0;

        // rst mid-fetch restores reset values and clears registers
        n = 0;
        while (!read_l1i && n < 40) begin
            tick();
            n++;
        end
        check("pre_rst_fetch", read_l1i, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_read", read_l1i, 1'b0);
        check("mid_rst_pc", pc_out, 64'h0);
        check("mid_rst_addr", l1i_addr, 64'h0);
        check("mid_rst_in_use", in_use, 1'b0);
        check("mid_rst_alu_a", alu_a, 64'h0);
        fetch(enc(12'h003, 4'd2, 6'd0, 6'd3, 4'd1), 0, 64'h0);
        do_alu(8'h03, 64'h0, 64'h0, 1, 64'h0, 1'b0);
        wait_retire(64'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
